avalon_pipelined_responder: RTL and testbench

//  Avalon-MM responder (slave) with on-chip word memory, fixed-latency pipelined reads
//  and optional pseudo-random waitrequest stalls. It is the target the Avalon assertion

---
 rtl/avalon_pipelined_responder.sv | 93 +++++++++
 tb/tb_avalon_pipelined_responder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pipelined_responder.sv
// Avalon-MM responder: byte-lane word memory, fixed-latency pipelined reads,
// optional LFSR-driven waitrequest stalls, sticky protocol-error flag and transfer counters.
module avalon_pipelined_responder #(
    parameter int          NBDATABYTES = 2,
    parameter int          NBADDRBITS  = 8,
    parameter int          READLATENCY = 2,
    parameter bit          STALLEN     = 1'b0,
    parameter logic [15:0] LFSRSEED    = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NBADDRBITS-1:0]      address,
    input  logic [NBDATABYTES-1:0]     byteenable,
    input  logic [8*NBDATABYTES-1:0]   writedata,
    input  logic                       read,
    input  logic                       write,
    output logic                       waitrequest,
    output logic [8*NBDATABYTES-1:0]   readdata,
    output logic                       readdatavalid,
    output logic                       proto_err,
    output logic [15:0]                nb_reads,
    output logic [15:0]                nb_writes
);
    localparam int DW    = 8 * NBDATABYTES;
    localparam int DEPTH = 1 << NBADDRBITS;

    logic [DW-1:0]          mem_q [DEPTH];
    logic [15:0]            lfsr_q, lfsr_d;
    logic [READLATENCY-1:0] vld_q;
    logic [DW-1:0]          data_q [READLATENCY];
    logic                   perr_q;
    logic [15:0]            nrd_q, nwr_q;
    logic                   rd_acc, wr_acc;

    // Galois right-shift form of x^16+x^14+x^13+x^11.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    assign waitrequest = rst || (STALLEN && lfsr_q[0]);
    assign rd_acc      = read  && !write && !waitrequest;
    assign wr_acc      = write && !read  && !waitrequest;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            lfsr_q <= LFSRSEED;
            vld_q  <= '0;
            perr_q <= 1'b0;
            nrd_q  <= 16'h0000;
            nwr_q  <= 16'h0000;
        end else begin
            if (STALLEN) begin
                lfsr_q <= lfsr_d;
            end
            if (wr_acc) begin
                for (int b = 0; b < NBDATABYTES; b++) begin
                    if (byteenable[b]) begin
                        mem_q[address][8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
                nwr_q <= nwr_q + 16'd1;
            end
            if (rd_acc) begin
                nrd_q <= nrd_q + 16'd1;
            end
            if (read && write) begin
                perr_q <= 1'b1;
            end
            vld_q[0] <= rd_acc;
            for (int i = 1; i < READLATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Data stages carry no reset; the output is gated by the valid pipeline.
    always_ff @(posedge clk) begin
        data_q[0] <= mem_q[address];
        for (int i = 1; i < READLATENCY; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign readdatavalid = vld_q[READLATENCY-1];
    assign readdata      = vld_q[READLATENCY-1] ? data_q[READLATENCY-1] : '0;
    assign proto_err     = perr_q;
    assign nb_reads      = nrd_q;
    assign nb_writes     = nwr_q;

endmodule

// File: tb/tb_avalon_pipelined_responder.sv
// Bench for avalon_pipelined_responder: unit 0 without stalls (latency 2),
// unit 1 with LFSR stalls (latency 3); read responses checked against a timed queue.
module tb_avalon_pipelined_responder;
    localparam int LAT0 = 2;
    localparam int LAT1 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr [2];
    logic [1:0]  be   [2];
    logic [15:0] wd   [2];
    logic        rd   [2];
    logic        wr   [2];
    logic        wrq  [2];
    logic [15:0] rdata[2];
    logic        rdv  [2];
    logic        perr [2];
    logic [15:0] nrd  [2];
    logic [15:0] nwr  [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stalls   = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int          u;
        logic [15:0] d;
        int          due;
    } exp_t;
    exp_t        sbq [$];
    logic [15:0] mdl [2][256];
    int          exp_rd [2];
    int          exp_wr [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_pipelined_responder #(
        .NBDATABYTES(2), .NBADDRBITS(8), .READLATENCY(LAT0), .STALLEN(1'b0), .LFSRSEED(16'hACE1)
    ) u0 (
        .clk(clk), .rst(rst), .address(addr[0]), .byteenable(be[0]), .writedata(wd[0]),
        .read(rd[0]), .write(wr[0]), .waitrequest(wrq[0]), .readdata(rdata[0]),
        .readdatavalid(rdv[0]), .proto_err(perr[0]), .nb_reads(nrd[0]), .nb_writes(nwr[0])
    );

    avalon_pipelined_responder #(
        .NBDATABYTES(2), .NBADDRBITS(8), .READLATENCY(LAT1), .STALLEN(1'b1), .LFSRSEED(16'hACE1)
    ) u1 (
        .clk(clk), .rst(rst), .address(addr[1]), .byteenable(be[1]), .writedata(wd[1]),
        .read(rd[1]), .write(wr[1]), .waitrequest(wrq[1]), .readdata(rdata[1]),
        .readdatavalid(rdv[1]), .proto_err(perr[1]), .nb_reads(nrd[1]), .nb_writes(nwr[1])
    );

    // Response monitor: every valid beat must match the queue head in unit, data and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (rdv[u] === 1'b1) begin
                    if (sbq.size() == 0 || sbq[0].u != u) begin
                        failures++;
                        $display("FAIL unexpected_rdv unit=%0d cyc=%0d got readdata=%h required no response",
                                 u, cyc, rdata[u]);
                    end else begin
                        e = sbq.pop_front();
                        if (rdata[u] !== e.d || cyc != e.due) begin
                            failures++;
                            $display("FAIL rd_resp unit=%0d got data=%h cyc=%0d required data=%h cyc=%0d",
                                     u, rdata[u], cyc, e.d, e.due);
                        end
                    end
                end else if (rdv[u] !== 1'b0 || rdata[u] !== 16'h0000) begin
                    failures++;
                    $display("FAIL rdata_idle unit=%0d got rdv=%b readdata=%h required rdv=0 readdata=0000",
                             u, rdv[u], rdata[u]);
                end
            end
            if (sbq.size() > 0 && sbq[0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_rdv unit=%0d got none by cyc=%0d required data=%h at cyc=%0d",
                         sbq[0].u, cyc, sbq[0].d, sbq[0].due);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic clear_model();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 256; i++) mdl[u][i] = 16'h0000;
            exp_rd[u] = 0;
            exp_wr[u] = 0;
        end
    endtask

    task automatic idle_inputs();
        for (int u = 0; u < 2; u++) begin
            addr[u] = 8'h00; be[u] = 2'b00; wd[u] = 16'h0000; rd[u] = 1'b0; wr[u] = 1'b0;
        end
    endtask

    // Presents one command (called just after a rising edge) and holds it until accepted.
    task automatic xfer(input int u, input bit w, input logic [7:0] a, input logic [1:0] b,
                        input logic [15:0] d);
        int   n = 0;
        exp_t e;
        addr[u] = a; be[u] = b; wd[u] = d; rd[u] = !w; wr[u] = w;
        @(negedge clk);
        while (wrq[u] !== 1'b0 && n < 100) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout unit=%0d got waitrequest=%b required acceptance within 100 cycles",
                     u, wrq[u]);
        end else if (w) begin
            if (b[0]) mdl[u][a][7:0]  = d[7:0];
            if (b[1]) mdl[u][a][15:8] = d[15:8];
            exp_wr[u]++;
        end else begin
            e.u   = u;
            e.d   = mdl[u][a];
            e.due = cyc + ((u == 0) ? LAT0 : LAT1);
            sbq.push_back(e);
            exp_rd[u]++;
        end
        @(posedge clk);
        #1;
        rd[u] = 1'b0;
        wr[u] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sbq.size() > 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got %0d pending responses required 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic check_counters(input int u, input string name);
        checks++;
        if (nrd[u] !== 16'(exp_rd[u]) || nwr[u] !== 16'(exp_wr[u])) begin
            failures++;
            $display("FAIL %s_counters unit=%0d got reads=%0d writes=%0d required reads=%0d writes=%0d",
                     name, u, nrd[u], nwr[u], exp_rd[u], exp_wr[u]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (wrq[u] !== 1'b1 || rdv[u] !== 1'b0 || rdata[u] !== 16'h0 || perr[u] !== 1'b0
                || nrd[u] !== 16'h0 || nwr[u] !== 16'h0) begin
                failures++;
                $display("FAIL reset_state unit=%0d got wrq=%b rdv=%b rdata=%h perr=%b rd=%0d wr=%0d required 1 0 0000 0 0 0",
                         u, wrq[u], rdv[u], rdata[u], perr[u], nrd[u], nwr[u]);
            end
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        checks++;
        if (wrq[0] !== 1'b0) begin
            failures++;
            $display("FAIL nostall_wrq got %b required 0", wrq[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        xfer(0, 1'b1, 8'h10, 2'b11, 16'h1234);
        xfer(0, 1'b0, 8'h10, 2'b00, 16'h0000);
        wait_drain("write_read");
        check_counters(0, "write_read");
    endtask

    task automatic test_byteenable();
        xfer(0, 1'b1, 8'h20, 2'b11, 16'h1234);
        xfer(0, 1'b1, 8'h20, 2'b01, 16'hABCD);
        xfer(0, 1'b0, 8'h20, 2'b00, 16'h0000);
        xfer(0, 1'b1, 8'h20, 2'b00, 16'h5555);
        xfer(0, 1'b0, 8'h20, 2'b11, 16'h0000);
        xfer(0, 1'b1, 8'h21, 2'b10, 16'hBEEF);
        xfer(0, 1'b0, 8'h21, 2'b01, 16'h0000);
        wait_drain("byteenable");
        check_counters(0, "byteenable");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) xfer(0, 1'b1, 8'(i), 2'b11, 16'(i + 1));
        for (int i = 0; i < 4; i++) xfer(0, 1'b0, 8'(i), 2'b11, 16'h0000);
        for (int i = 0; i < 4; i++) xfer(0, 1'b0, 8'(3 - i), 2'b11, 16'h0000);
        wait_drain("back_to_back");
        check_counters(0, "back_to_back");
    endtask

    task automatic test_proto_err();
        addr[0] = 8'h10; be[0] = 2'b11; wd[0] = 16'hFFFF; rd[0] = 1'b1; wr[0] = 1'b1;
        @(posedge clk);
        #1;
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        checks++;
        if (perr[0] !== 1'b1 || perr[1] !== 1'b0) begin
            failures++;
            $display("FAIL proto_set got perr0=%b perr1=%b required 1 0", perr[0], perr[1]);
        end
        check_counters(0, "proto");
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (perr[0] !== 1'b1) begin
            failures++;
            $display("FAIL proto_sticky got %b required 1", perr[0]);
        end
        xfer(0, 1'b0, 8'h10, 2'b11, 16'h0000);
        wait_drain("proto");
        check_counters(0, "proto_after");
    endtask

    task automatic test_reset_midflight();
        xfer(0, 1'b0, 8'h10, 2'b11, 16'h0000);
        xfer(0, 1'b0, 8'h20, 2'b11, 16'h0000);
        @(negedge clk);
        #1;
        rst = 1'b1;
        sbq.delete();
        clear_model();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdv[0] !== 1'b0) begin
            failures++;
            $display("FAIL rdv_after_rst got %b required 0", rdv[0]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (rdv[0] !== 1'b0) begin
                failures++;
                $display("FAIL flushed_rdv cycle=%0d got %b required 0", i, rdv[0]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (perr[0] !== 1'b0) begin
            failures++;
            $display("FAIL proto_cleared got %b required 0", perr[0]);
        end
        check_counters(0, "midflight");
        xfer(0, 1'b0, 8'h10, 2'b11, 16'h0000);
        xfer(0, 1'b0, 8'h20, 2'b11, 16'h0000);
        xfer(0, 1'b0, 8'h03, 2'b11, 16'h0000);
        wait_drain("midflight");
    endtask

    task automatic test_stall_random();
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            bit w;
            w = 1'($urandom_range(0, 1));
            xfer(1, w, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 16'($urandom()));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain("stall");
        check_counters(1, "stall");
        checks++;
        if (stalls == 0) begin
            failures++;
            $display("FAIL stall_seen got %0d stalled cycles required >0", stalls);
        end
        checks++;
        if (perr[1] !== 1'b0) begin
            failures++;
            $display("FAIL stall_perr got %b required 0", perr[1]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byteenable();
        test_back_to_back();
        test_proto_err();
        test_reset_midflight();
        test_stall_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion required finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
